// File: rtl/gpu_dot_sequencer_if.sv
// gpu_dot_sequencer_if: host load/cmd/activation handshakes plus the gpu_top write/start/result bus.
// GPU_DOT_ZSKIP_CNT_EN adds the zskip_cnt status output.
interface gpu_dot_sequencer_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 ld_valid, ld_ready;
    logic [3:0]           ld_idx;
    logic [7:0]           ld_data;
    logic                 cmd_valid, cmd_ready;
    logic [3:0]           cmd_base;
    logic [4:0]           cmd_len;
    logic                 act_valid, act_ready;
    logic [7:0]           act_data;
    logic [ACC_WIDTH-1:0] dot_out;
    logic                 done, busy, timeout_err;
    logic                 g_mem_write_en;
    logic [3:0]           g_mem_write_idx;
    logic [7:0]           g_mem_write_val;
    logic                 g_start;
    logic [3:0]           g_weight_addr;
    logic [7:0]           g_activation;
    logic [63:0]          g_result;
    logic                 g_valid, g_zero_skipped;
`ifdef GPU_DOT_ZSKIP_CNT_EN
    logic [4:0]           zskip_cnt;
`endif

    modport master (
`ifdef GPU_DOT_ZSKIP_CNT_EN
        input  zskip_cnt,
`endif
        output ld_valid, ld_idx, ld_data, cmd_valid, cmd_base, cmd_len, act_valid, act_data,
               g_result, g_valid, g_zero_skipped,
        input  ld_ready, cmd_ready, act_ready, dot_out, done, busy, timeout_err,
               g_mem_write_en, g_mem_write_idx, g_mem_write_val, g_start, g_weight_addr, g_activation
    );

    modport slave (
`ifdef GPU_DOT_ZSKIP_CNT_EN
        output zskip_cnt,
`endif
        input  ld_valid, ld_idx, ld_data, cmd_valid, cmd_base, cmd_len, act_valid, act_data,
               g_result, g_valid, g_zero_skipped,
        output ld_ready, cmd_ready, act_ready, dot_out, done, busy, timeout_err,
               g_mem_write_en, g_mem_write_idx, g_mem_write_val, g_start, g_weight_addr, g_activation
    );
endinterface

// File: rtl/gpu_dot_sequencer.sv
// gpu_dot_sequencer: loads INT4 weights into gpu_top and sequences a cmd_len-element dot product.
// GPU_DOT_ZSKIP_CNT_EN adds a count of zero-skipped results.
module gpu_dot_sequencer #(
    parameter int ACC_WIDTH = 32,
    parameter int TIMEOUT   = 64
) (
    input logic                clk,
    input logic                rst_n,
    gpu_dot_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WAIT_ACT, ISSUE, WAIT_RES, FINISH} state_t;

    state_t               state;
    logic [3:0]           base;
    logic [4:0]           len, cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic [TW-1:0]        timer;
    logic                 unused_bits;

    assign bus.cmd_ready = state == IDLE;
    assign bus.ld_ready  = state == IDLE && !bus.cmd_valid;
    assign bus.act_ready = state == WAIT_ACT;
    assign bus.busy      = state != IDLE;
    assign unused_bits   = ^{bus.g_result, bus.g_zero_skipped};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            base                <= '0;
            len                 <= '0;
            cnt                 <= '0;
            acc                 <= '0;
            timer               <= '0;
            bus.dot_out         <= '0;
            bus.done            <= 1'b0;
            bus.timeout_err     <= 1'b0;
            bus.g_mem_write_en  <= 1'b0;
            bus.g_mem_write_idx <= '0;
            bus.g_mem_write_val <= '0;
            bus.g_start         <= 1'b0;
            bus.g_weight_addr   <= '0;
            bus.g_activation    <= '0;
`ifdef GPU_DOT_ZSKIP_CNT_EN
            bus.zskip_cnt       <= '0;
`endif
        end else begin
            bus.done           <= 1'b0;
            bus.g_mem_write_en <= 1'b0;
            bus.g_start        <= 1'b0;
            case (state)
                IDLE:
                    if (bus.cmd_valid) begin
                        base            <= bus.cmd_base;
                        len             <= bus.cmd_len;
                        cnt             <= '0;
                        acc             <= '0;
                        bus.timeout_err <= 1'b0;
`ifdef GPU_DOT_ZSKIP_CNT_EN
                        bus.zskip_cnt   <= '0;
`endif
                        state           <= bus.cmd_len == 5'd0 ? FINISH : WAIT_ACT;
                    end else if (bus.ld_valid) begin
                        bus.g_mem_write_en  <= 1'b1;
                        bus.g_mem_write_idx <= bus.ld_idx;
                        bus.g_mem_write_val <= bus.ld_data;
                    end
                // g_start is registered here so it is high for exactly the ISSUE cycle
                WAIT_ACT:
                    if (bus.act_valid) begin
                        bus.g_activation  <= bus.act_data;
                        bus.g_weight_addr <= base + cnt[3:0];
                        bus.g_start       <= 1'b1;
                        state             <= ISSUE;
                    end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_RES;
                end
                WAIT_RES:
                    if (bus.g_valid) begin
                        acc   <= acc + bus.g_result[ACC_WIDTH-1:0];
                        cnt   <= cnt + 5'd1;
`ifdef GPU_DOT_ZSKIP_CNT_EN
                        if (bus.g_zero_skipped) bus.zskip_cnt <= bus.zskip_cnt + 5'd1;
`endif
                        state <= cnt + 5'd1 == len ? FINISH : WAIT_ACT;
                    end else if (timer == T_LAST) begin
                        bus.timeout_err <= 1'b1;
                        state           <= FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                FINISH: begin
                    bus.dot_out <= acc;
                    bus.done    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_dot_sequencer.sv
// tb_gpu_dot_sequencer: directed checks of gpu_dot_sequencer against a 5-cycle multiply gpu model.
module tb_gpu_dot_sequencer;
    localparam int AW = 32;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic gpu_en = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   writes = 0;
    int   starts = 0;
    int   lat = 0;
    logic [3:0]  last_addr = '0, prev_addr = '0;
    logic [7:0]  mem [16];
    logic [63:0] prod = '0;

    gpu_dot_sequencer_if #(.ACC_WIDTH(AW)) bus();
    gpu_dot_sequencer #(.ACC_WIDTH(AW), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // gpu stand-in: result = weight nibble * activation, valid 5 cycles after start
    always @(posedge clk) begin
        if (bus.g_mem_write_en) begin
            mem[bus.g_mem_write_idx] <= bus.g_mem_write_val;
            writes <= writes + 1;
        end
        if (bus.g_start) begin
            starts    <= starts + 1;
            last_addr <= bus.g_weight_addr;
            prev_addr <= last_addr;
        end
        bus.g_valid <= 1'b0;
        if (!rst_n) begin
            lat                <= 0;
            bus.g_result       <= '0;
            bus.g_zero_skipped <= 1'b0;
        end else if (bus.g_start && gpu_en) begin
            lat  <= 5;
            prod <= 64'(mem[bus.g_weight_addr][3:0]) * 64'(bus.g_activation);
        end else if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                bus.g_valid        <= 1'b1;
                bus.g_result       <= prod;
                bus.g_zero_skipped <= prod == 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else passed++;
    endtask

    task automatic ld(input logic [3:0] i, input logic [7:0] d);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_idx   = i;
        bus.ld_data  = d;
    endtask

    task automatic ld_end;
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    // issue one command with a constant activation; returns cycles accept->done and g_start->done
    task automatic run(input logic [3:0] b, input logic [4:0] n, input logic [7:0] a,
                       output int cyc, output int slat);
        int sc;
        sc = -1;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = b;
        bus.cmd_len   = n;
        bus.act_valid = 1'b1;
        bus.act_data  = a;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 3000) begin
            if (bus.g_start) sc = cyc;
            @(negedge clk);
            cyc++;
        end
        bus.act_valid = 1'b0;
        slat = sc < 0 ? -1 : cyc - sc;
        check("done_seen", 64'(bus.done), 1);
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 0);
        check("idle_after", 64'(bus.busy), 0);
    endtask

    initial begin
        int cyc, slat, s0, w0, guard;
        logic seen;
        bus.ld_valid = 1'b0; bus.ld_idx = '0; bus.ld_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.act_valid = 1'b0; bus.act_data = '0;
        repeat (3) @(negedge clk);
        check("rst_dot", 64'(bus.dot_out), 0);
        check("rst_done", 64'(bus.done), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_err", 64'(bus.timeout_err), 0);
        check("rst_start", 64'(bus.g_start), 0);
        check("rst_wen", 64'(bus.g_mem_write_en), 0);
        check("rst_addr", 64'(bus.g_weight_addr), 0);
        check("rst_act", 64'(bus.g_activation), 0);
        rst_n = 1'b1;

        ld(0, 1); ld(1, 2); ld(2, 3); ld(3, 4);
        ld_end();
        check("ld_wen_last", 64'(bus.g_mem_write_en), 1);
        check("ld_idx_last", 64'(bus.g_mem_write_idx), 3);
        check("ld_val_last", 64'(bus.g_mem_write_val), 4);
        @(negedge clk);
        check("ld_wen_drop", 64'(bus.g_mem_write_en), 0);
        check("ld_writes", 64'(writes), 4);

        s0 = starts;
        run(0, 4, 2, cyc, slat);
        check("dot_basic", 64'(bus.dot_out), 20);
        check("err_basic", 64'(bus.timeout_err), 0);
        check("starts_basic", 64'(starts - s0), 4);

        ld(15, 5); ld(0, 6);
        ld_end();
        run(15, 2, 1, cyc, slat);
        check("dot_wrap", 64'(bus.dot_out), 11);
        check("addr_first", 64'(prev_addr), 15);
        check("addr_wrap", 64'(last_addr), 0);

        ld(2, 0);
        ld_end();
        run(2, 1, 9, cyc, slat);
        check("dot_zero", 64'(bus.dot_out), 0);
`ifdef GPU_DOT_ZSKIP_CNT_EN
        check("zskip", 64'(bus.zskip_cnt), 1);
`endif

        gpu_en = 1'b0;
        run(0, 1, 1, cyc, slat);
        check("to_err", 64'(bus.timeout_err), 1);
        check("to_dot", 64'(bus.dot_out), 0);
        check("to_lat_ok", 64'(slat >= TO && slat <= TO + 2), 1);
        gpu_en = 1'b1;
        run(0, 1, 3, cyc, slat);
        check("err_clear", 64'(bus.timeout_err), 0);
        check("dot_after_to", 64'(bus.dot_out), 18);

        // ld and cmd together: cmd wins, no write; empty run completes without a start
        w0 = writes;
        s0 = starts;
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_idx = 4'd5; bus.ld_data = 8'd7;
        bus.cmd_valid = 1'b1; bus.cmd_base = 4'd0; bus.cmd_len = 5'd0;
        #1 check("ld_ready_tie", 64'(bus.ld_ready), 0);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.cmd_valid = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("len0_cyc", 64'(cyc), 2);
        check("len0_dot", 64'(bus.dot_out), 0);
        check("len0_nostart", 64'(starts - s0), 0);
        check("tie_nowrite", 64'(writes - w0), 0);

        run(0, 1, 2, cyc, slat);
        check("dot_pre_rst", 64'(bus.dot_out), 12);

        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_base = 4'd0; bus.cmd_len = 5'd4;
        bus.act_valid = 1'b1; bus.act_data = 8'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        guard = 0;
        while (!bus.g_start && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rst_run_started", 64'(bus.g_start), 1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.act_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | bus.done;
        end
        check("mid_busy", 64'(bus.busy), 0);
        check("mid_dot", 64'(bus.dot_out), 0);
        check("mid_start", 64'(bus.g_start), 0);
        check("mid_err", 64'(bus.timeout_err), 0);
        check("mid_nodone", 64'(seen), 0);
        rst_n = 1'b1;
        ld(0, 1); ld(1, 2); ld(2, 3); ld(3, 4);
        ld_end();
        run(0, 4, 3, cyc, slat);
        check("dot_fresh", 64'(bus.dot_out), 30);
        check("err_fresh", 64'(bus.timeout_err), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
